// File: rtl/dfp_norm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : DFPPkg (package)
// Description : Shared decimal floating-point types for the DFP datapath,
//               plus the normalizer latency and the tag type used by the
//               normalizer arbiter. dfpna_oh2idx encodes a one-hot grant
//               (up to 8 requesters) into a requester index.
// Revision    : 1.0 - initial release
// ============================================================================
package DFPPkg;

    typedef logic [127:0] DFP128UD;   // unnormalized 128-bit DFP operand
    typedef logic [127:0] DFP128UN;   // normalized 128-bit DFP result

    localparam int DFPNORM_LAT = 8;   // normalizer latency in ce edges

    // Requester index width sized for the largest supported NREQ (8).
    localparam int c_dfpna_idw = 3;

    typedef struct packed {
        logic                   v;
        logic [c_dfpna_idw-1:0] id;
    } dfpna_tag_t;

    function automatic logic [c_dfpna_idw-1:0] dfpna_oh2idx(input logic [7:0] oh);
        logic [c_dfpna_idw-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | c_dfpna_idw'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfp_norm_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : dfp_rr_arbiter
// Description : Single-winner arbiter for the shared DFP normalizer.
//               With DFPNA_RR_EN defined, a pointer holds the last winner and
//               the search starts just above it (round robin). Without it,
//               the lowest eligible index wins and no pointer exists.
// Ports       : clk    - clock
//               rst_n  - synchronous active-low reset (pointer -> NREQ-1)
//               elig_i - eligible requesters
//               adv_i  - a transfer happens this cycle (pointer update)
//               gnt_o  - one-hot grant, or zero
// Macro       : DFPNA_RR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module dfp_rr_arbiter
    import DFPPkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] elig_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o
);

`ifdef DFPNA_RR_EN
    logic [c_dfpna_idw-1:0] r_ptr;
    logic [NREQ-1:0]        w_mask;
    logic [NREQ-1:0]        w_hi;
    logic [c_dfpna_idw-1:0] w_win;

    // Requesters above the pointer get first chance; if none of them is
    // eligible, the search wraps to the lowest eligible index.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_mask[k] = (c_dfpna_idw'(k) > r_ptr);
        end
        w_hi = elig_i & w_mask;
        if (|w_hi) begin
            gnt_o = w_hi & (~w_hi + NREQ'(1));
        end else begin
            gnt_o = elig_i & (~elig_i + NREQ'(1));
        end
    end

    assign w_win = dfpna_oh2idx(8'(gnt_o));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= c_dfpna_idw'(NREQ - 1);
        end else if (adv_i) begin
            r_ptr <= w_win;
        end
    end
`else
    logic w_unused;

    // Fixed priority: isolate the lowest set bit.
    assign gnt_o    = elig_i & (~elig_i + NREQ'(1));
    assign w_unused = ^{clk, rst_n, adv_i};
`endif

endmodule
`default_nettype wire

// File: rtl/dfp_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dfp_norm_arbiter
// Description : Shares one 128-bit DFP normalizer among NREQ requesters.
//               One operand is granted per ce cycle. A LAT-deep tag pipeline
//               tracks who issued each operand and steers the normalizer
//               output back as a one-hot result strobe. flush_i[k] cancels
//               every in-flight operation of requester k.
// Ports       : clk, rst_n (sync, active-low), ce
//               req_i/dat_i/under_i/flush_i - per-requester inputs
//               gnt_o                        - one-hot grant
//               norm_dat_o/norm_under_o/norm_ce_o - normalizer input side
//               norm_dat_i/norm_under_i/norm_inexact_i - normalizer output
//               res_vld_o/res_o/res_under_o/res_inexact_o - results
//               inflight_o/busy_o            - valid tag count / non-zero
// Macro       : DFPNA_RR_EN (round robin when defined, else fixed priority)
// Revision    : 1.0 - initial release
// ============================================================================
module dfp_norm_arbiter
    import DFPPkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = DFPNORM_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [NREQ-1:0]          req_i,
    input  DFP128UD                  dat_i [NREQ],
    input  logic [NREQ-1:0]          under_i,
    input  logic [NREQ-1:0]          flush_i,
    output logic [NREQ-1:0]          gnt_o,
    output DFP128UD                  norm_dat_o,
    output logic                     norm_under_o,
    output logic                     norm_ce_o,
    input  DFP128UN                  norm_dat_i,
    input  logic                     norm_under_i,
    input  logic                     norm_inexact_i,
    output logic [NREQ-1:0]          res_vld_o,
    output DFP128UN                  res_o,
    output logic                     res_under_o,
    output logic                     res_inexact_o,
    output logic [$clog2(LAT+1)-1:0] inflight_o,
    output logic                     busy_o
);

    localparam int CW = $clog2(LAT + 1);

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_gnt;
    logic                   w_xfer;
    logic [c_dfpna_idw-1:0] w_win;
    logic [7:0]             w_flush8;
    dfpna_tag_t             r_tag     [LAT];
    dfpna_tag_t             w_tag_nxt [LAT];
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_kill;
    logic [CW-1:0]          w_cnt_nxt;

    // rst_n is folded in so no grant or result is visible while in reset.
    assign w_elig   = req_i & ~flush_i & {NREQ{ce & rst_n}};
    assign w_xfer   = |w_gnt;
    assign w_win    = dfpna_oh2idx(8'(w_gnt));
    assign w_flush8 = 8'(flush_i);

    dfp_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .elig_i (w_elig),
        .adv_i  (w_xfer),
        .gnt_o  (w_gnt)
    );

    assign gnt_o     = w_gnt;
    assign norm_ce_o = ce;

    always_comb begin
        norm_dat_o   = '0;
        norm_under_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                norm_dat_o   = norm_dat_o | dat_i[k];
                norm_under_o = norm_under_o | under_i[k];
            end
        end
    end

    // Shift the tags; a tag whose owner is flushing is invalidated as it
    // moves. Kills in the last stage are not counted here because that tag
    // leaves the pipe this edge regardless.
    always_comb begin
        for (int n = 0; n < LAT; n++) begin
            w_tag_nxt[n] = '0;
        end
        w_tag_nxt[0].v  = w_xfer;
        w_tag_nxt[0].id = w_win;
        w_kill          = '0;
        for (int n = 1; n < LAT; n++) begin
            w_tag_nxt[n] = r_tag[n-1];
            if (r_tag[n-1].v && w_flush8[r_tag[n-1].id]) begin
                w_tag_nxt[n].v = 1'b0;
                w_kill         = w_kill + CW'(1);
            end
        end
        w_cnt_nxt = r_cnt + CW'(w_xfer) - CW'(r_tag[LAT-1].v) - w_kill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < LAT; n++) begin
                r_tag[n] <= '0;
            end
            r_cnt <= '0;
        end else if (ce) begin
            r_tag <= w_tag_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        res_vld_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            res_vld_o[k] = r_tag[LAT-1].v && (r_tag[LAT-1].id == c_dfpna_idw'(k))
                           && !flush_i[k] && ce && rst_n;
        end
    end

    assign res_o         = norm_dat_i;
    assign res_under_o   = norm_under_i;
    assign res_inexact_o = norm_inexact_i;
    assign inflight_o    = r_cnt;
    assign busy_o        = |r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dfp_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfp_norm_arbiter
// Description : Directed self-checking bench for dfp_norm_arbiter with
//               NREQ=4, LAT=8. Inputs change on the falling edge; outputs
//               are sampled 1 time unit later, mid-cycle. Cycle c of a test
//               ends with the rising edge that performs cycle c's transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfp_norm_arbiter;
    import DFPPkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b1;
    logic [3:0]    req = '0;
    DFP128UD       dat [4];
    logic [3:0]    under = '0;
    logic [3:0]    flush = '0;
    logic [3:0]    gnt;
    DFP128UD       norm_dat_o;
    logic          norm_under_o;
    logic          norm_ce_o;
    DFP128UN       norm_dat_i = '0;
    logic          norm_under_i = 1'b0;
    logic          norm_inexact_i = 1'b0;
    logic [3:0]    res_vld;
    DFP128UN       res;
    logic          res_under;
    logic          res_inexact;
    logic [3:0]    inflight;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dfp_norm_arbiter #(.NREQ(4), .LAT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce             (ce),
        .req_i          (req),
        .dat_i          (dat),
        .under_i        (under),
        .flush_i        (flush),
        .gnt_o          (gnt),
        .norm_dat_o     (norm_dat_o),
        .norm_under_o   (norm_under_o),
        .norm_ce_o      (norm_ce_o),
        .norm_dat_i     (norm_dat_i),
        .norm_under_i   (norm_under_i),
        .norm_inexact_i (norm_inexact_i),
        .res_vld_o      (res_vld),
        .res_o          (res),
        .res_under_o    (res_under),
        .res_inexact_o  (res_inexact),
        .inflight_o     (inflight),
        .busy_o         (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ce = 1'b1; req = '0; flush = '0; under = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; ce = 1'b1; req = 4'hF;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (res_vld !== 4'b0000) begin failures++; $display("FAIL reset_res_vld got=%b exp=0000", res_vld); end
        checks++; if (norm_dat_o !== '0) begin failures++; $display("FAIL reset_norm_dat got=%h exp=0", norm_dat_o); end
        @(negedge clk);
        req = '0;
        #1;
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] exp_v;
        logic [3:0] exp_n;
        do_reset();
        req = 4'b0100; under = 4'b0100;
        norm_dat_i = 128'h2222_0000_1111_0000_3333_0000_4444_0000;
        norm_under_i = 1'b1; norm_inexact_i = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (norm_dat_o !== dat[2]) begin failures++; $display("FAIL single_norm_dat got=%h exp=%h", norm_dat_o, dat[2]); end
        checks++; if (norm_under_o !== 1'b1) begin failures++; $display("FAIL single_norm_under got=%b exp=1", norm_under_o); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
        @(negedge clk);
        req = '0; under = '0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            exp_v = (c == 8) ? 4'b0100 : 4'b0000;
            exp_n = (c <= 8) ? 4'd1 : 4'd0;
            checks++; if (res_vld !== exp_v) begin failures++; $display("FAIL single_res_vld c=%0d got=%b exp=%b", c, res_vld, exp_v); end
            checks++; if (inflight !== exp_n) begin failures++; $display("FAIL single_inflight c=%0d got=%0d exp=%0d", c, inflight, exp_n); end
            checks++; if (busy !== (exp_n != 0)) begin failures++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
            if (c == 8) begin
                checks++; if (res !== 128'h2222_0000_1111_0000_3333_0000_4444_0000) begin failures++; $display("FAIL single_res got=%h", res); end
                checks++; if (res_under !== 1'b1 || res_inexact !== 1'b0) begin failures++; $display("FAIL single_flags got=%b%b exp=10", res_under, res_inexact); end
            end
            @(negedge clk);
        end
        norm_under_i = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [3:0] g_hist [21];
        logic [3:0] exp_g;
        logic [3:0] exp_r;
        logic [3:0] one;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            req = (c < 9) ? 4'hF : 4'h0;
            one = 4'b0001;
`ifdef DFPNA_RR_EN
            exp_g = (c < 9) ? (one << (c % 4)) : 4'b0000;
`else
            exp_g = (c < 9) ? one : 4'b0000;
`endif
            g_hist[c] = exp_g;
            exp_r = (c >= 8 && c <= 16) ? g_hist[c-8] : 4'b0000;
            #1;
            checks++; if (gnt !== exp_g) begin failures++; $display("FAIL arb_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            checks++; if (res_vld !== exp_r) begin failures++; $display("FAIL arb_res_vld c=%0d got=%b exp=%b", c, res_vld, exp_r); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_mid();
        logic [3:0] seq [3];
        logic [3:0] exp_v;
        logic [3:0] exp_n;
        seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0010;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            req   = (c < 3) ? seq[c] : 4'b0000;
            flush = (c == 4) ? 4'b0010 : 4'b0000;
            #1;
            if (c < 3) begin
                checks++; if (gnt !== seq[c]) begin failures++; $display("FAIL flush_gnt c=%0d got=%b exp=%b", c, gnt, seq[c]); end
            end
            exp_n = (c <= 4) ? 4'(c > 3 ? 3 : c) : ((c <= 9) ? 4'd1 : 4'd0);
            exp_v = (c == 9) ? 4'b1000 : 4'b0000;
            checks++; if (inflight !== exp_n) begin failures++; $display("FAIL flush_inflight c=%0d got=%0d exp=%0d", c, inflight, exp_n); end
            checks++; if (res_vld !== exp_v) begin failures++; $display("FAIL flush_res_vld c=%0d got=%b exp=%b", c, res_vld, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_coincident();
        do_reset();
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL coin_gnt0 got=%b exp=0001", gnt); end
        @(negedge clk);
        req = '0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        req = 4'b0001; flush = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL coin_gnt got=%b exp=0000", gnt); end
        checks++; if (res_vld !== 4'b0000) begin failures++; $display("FAIL coin_res_vld got=%b exp=0000", res_vld); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL coin_inflight8 got=%0d exp=1", inflight); end
        @(negedge clk);
        req = '0; flush = '0;
        #1;
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL coin_inflight9 got=%0d exp=0", inflight); end
        checks++; if (res_vld !== 4'b0000) begin failures++; $display("FAIL coin_res_vld9 got=%b exp=0000", res_vld); end
        @(negedge clk);
    endtask

    task automatic test_ce_stall();
        logic [3:0] exp_v;
        logic [3:0] exp_n;
        logic       stall;
        do_reset();
        req = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL stall_gnt0 got=%b exp=0100", gnt); end
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            stall = (c >= 3 && c <= 7);
            req   = stall ? 4'b0010 : 4'b0000;
            ce    = !stall;
            #1;
            exp_v = (c == 13) ? 4'b0100 : 4'b0000;
            exp_n = (c <= 13) ? 4'd1 : 4'd0;
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL stall_gnt c=%0d got=%b exp=0000", c, gnt); end
            checks++; if (norm_ce_o !== ce) begin failures++; $display("FAIL stall_norm_ce c=%0d got=%b exp=%b", c, norm_ce_o, ce); end
            checks++; if (res_vld !== exp_v) begin failures++; $display("FAIL stall_res_vld c=%0d got=%b exp=%b", c, res_vld, exp_v); end
            checks++; if (inflight !== exp_n) begin failures++; $display("FAIL stall_inflight c=%0d got=%0d exp=%0d", c, inflight, exp_n); end
            @(negedge clk);
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'hF;
        for (int c = 0; c < 6; c++) @(negedge clk);
        #1;
        checks++; if (inflight !== 4'd6) begin failures++; $display("FAIL rmid_inflight6 got=%0d exp=6", inflight); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy6 got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rmid_gnt_in_reset got=%b exp=0000", gnt); end
        @(negedge clk);
        rst_n = 1'b1; req = '0;
        #1;
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL rmid_inflight got=%0d exp=0", inflight); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        for (int c = 7; c <= 19; c++) begin
            checks++; if (res_vld !== 4'b0000) begin failures++; $display("FAIL rmid_res_vld c=%0d got=%b exp=0000", c, res_vld); end
            @(negedge clk);
            #1;
        end
        req = 4'hF;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_next_gnt got=%b exp=0001", gnt); end
        @(negedge clk);
        req = '0;
    endtask

    initial begin
        dat[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        dat[1] = 128'h1000_A1A1_B1B1_C1C1_D1D1_E1E1_F1F1_0101;
        dat[2] = 128'h2000_A2A2_B2B2_C2C2_D2D2_E2E2_F2F2_0202;
        dat[3] = 128'h3000_A3A3_B3B3_C3C3_D3D3_E3E3_F3F3_0303;
        test_reset();
        test_single();
        test_arbitration();
        test_flush_mid();
        test_flush_coincident();
        test_ce_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
